// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, data port and memory bus of the shared single-port memory
//   slave  - arbiter side: takes requests and m_rdata, drives grants, returns, stalls, memory controls
//   master - pipeline + memory side: the mirror image
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_flush;
    logic              i_gnt;
    logic              i_valid;
    logic [DATA_W-1:0] i_rdata;
    logic              i_stall;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    modport slave (
        input  i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_gnt, i_valid, i_rdata, i_stall, d_gnt, d_valid, d_rdata, d_stall,
               m_en, m_we, m_addr, m_wdata
    );
    modport master (
        output i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_valid, i_rdata, i_stall, d_gnt, d_valid, d_rdata, d_stall,
               m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one sync-read memory between the fetch port and the MEM-stage data port
//   clk, rst - clock and synchronous active-high reset
//   bus      - fetch request/grant/return, data request/grant/return, per-port stalls, memory bus
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input logic          clk,
    input logic          rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {NONE, FETCH, DATA} pend_t;
    pend_t             pend_q, pend_d;
    logic [3:0]        starve_q, starve_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              fetch_ok, starved, i_gnt, d_gnt, i_valid, d_valid;
    always_comb begin
        fetch_ok  = bus.i_req & ~bus.i_flush & ~rst;
        starved   = starve_q == 4'(STARVE_MAX);
        // data has priority unless fetch has waited through STARVE_MAX data grants
        d_gnt     = bus.d_req & ~rst & ~(fetch_ok & starved);
        i_gnt     = fetch_ok & ~d_gnt;
        // a flush in the return cycle squashes the fetch data
        i_valid   = ~rst & (pend_q == FETCH) & ~bus.i_flush;
        d_valid   = ~rst & (pend_q == DATA);
        pend_d    = i_gnt ? FETCH : (d_gnt & ~bus.d_we) ? DATA : NONE;
        starve_d  = (i_gnt | ~bus.i_req) ? 4'd0 :
                    (d_gnt & fetch_ok & ~starved) ? starve_q + 4'd1 : starve_q;
        i_rdata_d = i_valid ? bus.m_rdata : i_rdata_q;
        d_rdata_d = d_valid ? bus.m_rdata : d_rdata_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= NONE;
            starve_q  <= 4'd0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            pend_q    <= pend_d;
            starve_q  <= starve_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end
    // read data passes straight through in the return cycle and is held afterwards
    assign bus.i_gnt   = i_gnt;
    assign bus.i_valid = i_valid;
    assign bus.i_rdata = i_rdata_d;
    assign bus.i_stall = ~rst & bus.i_req & ~i_gnt;
    assign bus.d_gnt   = d_gnt;
    assign bus.d_valid = d_valid;
    assign bus.d_rdata = d_rdata_d;
    // a data read keeps MEM stalled from its grant through its return cycle
    assign bus.d_stall = ~rst & ((bus.d_req & ~d_gnt) | (d_gnt & ~bus.d_we) | d_valid);
    assign bus.m_en    = i_gnt | d_gnt;
    assign bus.m_we    = d_gnt & bus.d_we;
    assign bus.m_addr  = i_gnt ? bus.i_addr : d_gnt ? bus.d_addr : '0;
    assign bus.m_wdata = d_gnt ? bus.d_wdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grants, returns, stalls, starvation, flush and reset
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] mem [256];

    mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.m_en && bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
        if (bus.m_en && !bus.m_we) bus.m_rdata <= mem[bus.m_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic ir, input logic [7:0] ia, input logic fl,
                       input logic dr, input logic we, input logic [7:0] da, input logic [31:0] wd);
        bus.i_req = ir; bus.i_addr = ia; bus.i_flush = fl;
        bus.d_req = dr; bus.d_we = we; bus.d_addr = da; bus.d_wdata = wd;
    endtask

    function automatic logic [31:0] flags();
        return {25'd0, bus.i_gnt, bus.d_gnt, bus.i_valid, bus.d_valid, bus.i_stall, bus.d_stall, bus.m_en};
    endfunction

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'hA000_0000 | k;
        mem[4] = 32'h2008_0005;
        bus.m_rdata = '0;
        rst = 1'b1;
        drv(1, 8'h04, 0, 1, 0, 8'h10, 0);
        nx();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_flags", flags(), 0);
            chk("rst_irdata", bus.i_rdata, 0);
            chk("rst_drdata", bus.d_rdata, 0);
            nx();
        end
        rst = 1'b0;
        // fetch only
        drv(1, 8'h04, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("f1_flags", flags(), 32'h41);
        chk("f1_maddr", 32'(bus.m_addr), 32'h04);
        nx();
        drv(1, 8'h05, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("f2_flags", flags(), 32'h51);
        chk("f2_rdata", bus.i_rdata, 32'h2008_0005);
        nx();
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("f3_flags", flags(), 32'h10);
        chk("f3_rdata", bus.i_rdata, 32'hA000_0005);
        nx();
        @(negedge clk);
        chk("f4_flags", flags(), 0);
        chk("f4_hold", bus.i_rdata, 32'hA000_0005);
        nx();
        // starvation: three data reads, then fetch, then data
        drv(1, 8'h06, 0, 1, 0, 8'd10, 0);
        @(negedge clk);
        chk("s1_flags", flags(), 32'h27);
        nx();
        drv(1, 8'h06, 0, 1, 0, 8'd11, 0);
        @(negedge clk);
        chk("s2_flags", flags(), 32'h2F);
        chk("s2_rdata", bus.d_rdata, 32'hA000_000A);
        nx();
        drv(1, 8'h06, 0, 1, 0, 8'd12, 0);
        @(negedge clk);
        chk("s3_flags", flags(), 32'h2F);
        chk("s3_rdata", bus.d_rdata, 32'hA000_000B);
        nx();
        drv(1, 8'h06, 0, 1, 0, 8'd13, 0);
        @(negedge clk);
        chk("s4_flags", flags(), 32'h4B);
        chk("s4_maddr", 32'(bus.m_addr), 32'h06);
        chk("s4_rdata", bus.d_rdata, 32'hA000_000C);
        nx();
        drv(0, 0, 0, 1, 0, 8'd13, 0);
        @(negedge clk);
        chk("s5_flags", flags(), 32'h33);
        chk("s5_irdata", bus.i_rdata, 32'hA000_0006);
        nx();
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("s6_flags", flags(), 32'h0A);
        chk("s6_rdata", bus.d_rdata, 32'hA000_000D);
        nx();
        @(negedge clk);
        chk("s7_flags", flags(), 0);
        nx();
        // write then read-back
        drv(0, 0, 0, 1, 1, 8'h20, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("w1_flags", flags(), 32'h21);
        chk("w1_mwe", 32'(bus.m_we), 1);
        chk("w1_wdata", bus.m_wdata, 32'hDEAD_BEEF);
        nx();
        drv(0, 0, 0, 1, 0, 8'h20, 0);
        @(negedge clk);
        chk("w2_flags", flags(), 32'h23);
        chk("w2_mwe", 32'(bus.m_we), 0);
        nx();
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("w3_flags", flags(), 32'h0A);
        chk("w3_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        nx();
        @(negedge clk);
        chk("w4_flags", flags(), 0);
        nx();
        // flush cancels a returning fetch and blocks a new one
        drv(1, 8'h04, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("x1_flags", flags(), 32'h41);
        nx();
        drv(0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("x2_flags", flags(), 0);
        chk("x2_hold", bus.i_rdata, 32'hA000_0006);
        nx();
        drv(1, 8'h04, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("x3_flags", flags(), 32'h04);
        nx();
        drv(1, 8'h04, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("x4_flags", flags(), 32'h41);
        nx();
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("x5_flags", flags(), 32'h10);
        chk("x5_rdata", bus.i_rdata, 32'h2008_0005);
        nx();
        // reset while a fetch is outstanding
        drv(1, 8'h05, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("r1_flags", flags(), 32'h41);
        nx();
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("r2_flags", flags(), 0);
        nx();
        rst = 1'b0;
        @(negedge clk);
        chk("r3_flags", flags(), 0);
        chk("r3_rdata", bus.i_rdata, 0);
        nx();
        drv(1, 8'h05, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("r4_flags", flags(), 32'h41);
        nx();
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("r5_flags", flags(), 32'h10);
        chk("r5_rdata", bus.i_rdata, 32'hA000_0005);
        nx();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous-read memory between the instruction-fetch port (read only) and the MEM-stage data port (read/write) of the 5-stage pipeline.
- Grants one port per cycle and returns read data one cycle after the grant.
- Generates per-port stall signals consumed by the pc / if_id / ex_mem hold logic.
- Supports a fetch-cancel input driven by the branch/jump flush, so a squashed fetch never delivers data.

Parameters:
ADDR_W, 8, word address width (256-word memory)
DATA_W, 32, data width
STARVE_MAX, 3, consecutive data grants allowed while fetch is waiting before fetch is forced a grant (1..15)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
i_req  in  1  fetch request; held until i_gnt
i_addr  in  ADDR_W  fetch word address
i_flush  in  1  cancel any outstanding/pending fetch (pipeline flush)
i_gnt  out  1  fetch granted this cycle (combinational)
i_valid  out  1  fetch data valid (one-cycle pulse)
i_rdata  out  DATA_W  fetch data, held until next i_valid
i_stall  out  1  i_req & ~i_gnt
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  write data
d_gnt  out  1  data granted this cycle (combinational)
d_valid  out  1  read data valid (one-cycle pulse; never for writes)
d_rdata  out  DATA_W  read data, held until next d_valid
d_stall  out  1  (d_req & ~d_gnt) | (read pending, d_valid not yet asserted)
m_en  out  1  memory access enable
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data, valid cycle after m_en & ~m_we

Behaviour:
- Reset (rst=1 at edge): pend_port=NONE, starve_cnt=0, i_valid=0, d_valid=0, i_rdata=0, d_rdata=0. The outstanding read is dropped with no valid pulse. Combinational outputs are 0 while rst=1.
- Grant rule, combinational, evaluated each cycle with rst=0:
  - Only d_req: d_gnt=1.
  - Only i_req and ~i_flush: i_gnt=1.
  - Both requested: d_gnt=1 unless starve_cnt==STARVE_MAX, in which case i_gnt=1.
  - i_flush=1 forces i_gnt=0 that cycle.
  - At most one grant per cycle.
- Memory drive: m_en = i_gnt|d_gnt; m_we = d_gnt & d_we; m_addr/m_wdata come from the granted port, and are 0 when idle.
- Pend register (captures granted reads at the edge):
  - pend_port <= FETCH if i_gnt; DATA if d_gnt & ~d_we; else NONE.
  - Reads are back-to-back capable: a new grant can occur in the cycle data returns.
- Return cycle (pend_port != NONE):
  - FETCH: i_valid=1 and i_rdata<=m_rdata, unless i_flush is high that cycle. A flush suppresses the pulse and leaves i_rdata unchanged.
  - DATA: d_valid=1 and d_rdata<=m_rdata. The data return is unaffected by flush.
- Latency: grant cycle N -> valid in cycle N+1 (registered outputs updated at the end of N). Writes complete in the grant cycle.
- Starvation counter:
  - Increments on d_gnt while i_req & ~i_flush; saturates at STARVE_MAX.
  - Clears on i_gnt or when i_req=0.
  - Width is 4 bits.
- Data-read stall: d_stall is held high during the grant cycle and until d_valid (the pend cycle), so the MEM stage sees the result before advancing.
- Simultaneous events:
  - i_flush together with i_req: no fetch grant; d_req may still be granted.
  - rst together with any request: no grant, outputs 0.
  - d_req with d_we and i_req at starve limit: fetch wins, and the write waits one cycle.

Test Plan:
- rst=1 for 2 cycles with i_req=d_req=1 -> all gnt/valid/stall/m_en=0, i_rdata=d_rdata=0.
- Only i_req, i_addr=8'h04, memory word[4]=32'h2008_0005 -> i_gnt in cycle 1, i_valid with i_rdata=32'h2008_0005 in cycle 2. Continuous i_req yields a grant every cycle.
- i_req held, d_req reads at addresses 10,11,12,13 back-to-back, STARVE_MAX=3 -> d_gnt for 3 cycles, i_gnt in 4th cycle, d_gnt in 5th. d_valid returns data in order; i_stall high for 3 cycles.
- d_req write addr 8'h20 data 32'hDEAD_BEEF, next cycle d_req read 8'h20 -> m_we pulse in cycle 1, no d_valid. d_valid with 32'hDEAD_BEEF in cycle 3; d_stall high in cycles 2-3 only.
- i_gnt in cycle N, i_flush=1 in N+1 -> no i_valid, i_rdata keeps previous value. A fetch request with i_flush high is not granted.
- Fetch granted in cycle N, rst=1 in N+1 -> no i_valid in N+1 or later. pend_port=NONE, and the first request after reset is granted normally.
